// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU/load encodings and the
// control and ID/EX bundles passed between the decode-stage blocks.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        LM_WORD   = 2'b00,
        LM_BYTE_S = 2'b01,
        LM_BYTE_U = 2'b10,
        LM_RSVD   = 2'b11
    } load_mode_e;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        alu_op_e    alu_op;
        load_mode_e load_mode;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, LM_WORD};

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] ext_imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] pc_plus4;
        ctrl_t       ctrl;
    } idex_t;

    function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational main-control decoder: maps the primary opcode to the
// ID/EX control bundle; unknown opcodes decode to an all-zero bubble.
module id_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT, LM_WORD};
            OP_LW:    ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD,   LM_WORD};
            OP_LB:    ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD,   LM_BYTE_S};
            OP_LBU:   ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD,   LM_BYTE_U};
            OP_SW:    ctrl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD,   LM_WORD};
            OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB,   LM_WORD};
            OP_ADDI:  ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD,   LM_WORD};
            OP_SLTI:  ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SLT,   LM_WORD};
            default:  ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded instruction every cycle,
// cleared to a bubble by synchronous reset.
module id_ex_pipe_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc_plus4,
    input  ctrl_t       ctrl,
    output idex_t       idex_out
);

    idex_t idex_d;
    idex_t idex_q;

    always_comb begin
        idex_d          = idex_q;
        idex_d.rd       = rd;
        idex_d.rt       = rt;
        idex_d.ext_imm  = ext_imm;
        idex_d.rs_data  = rs_data;
        idex_d.rt_data  = rt_data;
        idex_d.pc_plus4 = pc_plus4;
        idex_d.ctrl     = ctrl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex_out = idex_q;

endmodule

// File: rtl/id_regfile.sv
// 32x32 register file with two combinational read ports, write-through
// bypass from the WB port, and $0 hard-wired to zero.
module id_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [31:0] seed,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_fire;

    assign wr_fire = wr_en && !rst && (wr_addr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Reset reseeds every register except $0 and wins over a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= seed;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs_data = (rs_addr == 5'd0)                ? 32'd0   :
                     (wr_fire && (wr_addr == rs_addr)) ? wr_data : regs_q[rs_addr];
    assign rt_data = (rt_addr == 5'd0)                ? 32'd0   :
                     (wr_fire && (wr_addr == rt_addr)) ? wr_data : regs_q[rt_addr];

endmodule

// File: rtl/id_decode_stage.sv
// MIPS ID stage top: wires control decode, register file and the ID/EX
// register together; no logic of its own.
module id_decode_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] in_new_pc_value,
    input  logic [5:0]  write_register,
    input  logic [31:0] write_data,
    input  logic        in_RegWrite,
    input  logic [31:0] register_input,
    output logic [4:0]  instr_bits_15_11,
    output logic [4:0]  instr_bits_20_16,
    output logic [31:0] extended_bits,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] new_pc_value,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        Branch,
    output logic [1:0]  load_mode,
    output logic [2:0]  ALUOp
);

    ctrl_t       ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    idex_t       idex;
    logic        unused_wr_bit5;

    // Only 32 registers exist, so the WB address MSB carries no information.
    assign unused_wr_bit5 = write_register[5];

    id_ctrl_decode u_ctrl (
        .opcode (instruction[31:26]),
        .ctrl   (ctrl)
    );

    id_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (instruction[25:21]),
        .rt_addr (instruction[20:16]),
        .wr_addr (write_register[4:0]),
        .wr_data (write_data),
        .wr_en   (in_RegWrite),
        .seed    (register_input),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    id_ex_pipe_reg u_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd       (instruction[15:11]),
        .rt       (instruction[20:16]),
        .ext_imm  (sign_extend16(instruction[15:0])),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .pc_plus4 (in_new_pc_value),
        .ctrl     (ctrl),
        .idex_out (idex)
    );

    assign instr_bits_15_11 = idex.rd;
    assign instr_bits_20_16 = idex.rt;
    assign extended_bits    = idex.ext_imm;
    assign read_data1       = idex.rs_data;
    assign read_data2       = idex.rt_data;
    assign new_pc_value     = idex.pc_plus4;
    assign RegDst           = idex.ctrl.reg_dst;
    assign RegWrite         = idex.ctrl.reg_write;
    assign ALUSrc           = idex.ctrl.alu_src;
    assign MemWrite         = idex.ctrl.mem_write;
    assign MemRead          = idex.ctrl.mem_read;
    assign MemToReg         = idex.ctrl.mem_to_reg;
    assign Branch           = idex.ctrl.branch;
    assign load_mode        = idex.ctrl.load_mode;
    assign ALUOp            = idex.ctrl.alu_op;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed vectors push hand-computed
// ID/EX expectations; a monitor pops one per clock and compares.
module tb_id_decode_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] ext;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [6:0]  ctl;
        logic [2:0]  alu;
        logic [1:0]  lm;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic [31:0] in_new_pc_value = '0;
    logic [5:0]  write_register = '0;
    logic [31:0] write_data = '0;
    logic        in_RegWrite = 1'b0;
    logic [31:0] register_input = 32'hA5A5_0001;

    logic [4:0]  instr_bits_15_11;
    logic [4:0]  instr_bits_20_16;
    logic [31:0] extended_bits;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] new_pc_value;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
    logic [1:0]  load_mode;
    logic [2:0]  ALUOp;

    sb_item_t sb_q[$];
    int       tests = 0;
    int       failures = 0;
    out_t     actual;

    localparam logic [6:0] CTL_R   = 7'b1100000;
    localparam logic [6:0] CTL_LD  = 7'b0110110;
    localparam logic [6:0] CTL_SW  = 7'b0011000;
    localparam logic [6:0] CTL_BEQ = 7'b0000001;
    localparam logic [6:0] CTL_IMM = 7'b0110000;
    localparam out_t       ZERO    = '0;

    id_decode_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .in_new_pc_value  (in_new_pc_value),
        .write_register   (write_register),
        .write_data       (write_data),
        .in_RegWrite      (in_RegWrite),
        .register_input   (register_input),
        .instr_bits_15_11 (instr_bits_15_11),
        .instr_bits_20_16 (instr_bits_20_16),
        .extended_bits    (extended_bits),
        .read_data1       (read_data1),
        .read_data2       (read_data2),
        .new_pc_value     (new_pc_value),
        .RegDst           (RegDst),
        .RegWrite         (RegWrite),
        .ALUSrc           (ALUSrc),
        .MemWrite         (MemWrite),
        .MemRead          (MemRead),
        .MemToReg         (MemToReg),
        .Branch           (Branch),
        .load_mode        (load_mode),
        .ALUOp            (ALUOp)
    );

    always #5 clk = ~clk;

    assign actual = '{instr_bits_15_11, instr_bits_20_16, extended_bits, read_data1, read_data2,
                      new_pc_value, {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch},
                      ALUOp, load_mode};

    function automatic out_t mk(input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] ext,
                                input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                                input logic [6:0] ctl, input logic [2:0] alu, input logic [1:0] lm);
        return '{rd, rt, ext, rd1, rd2, pc, ctl, alu, lm};
    endfunction

    task automatic applyStimulus(input string name, input logic r, input logic [31:0] seed,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [5:0] wreg, input logic [31:0] wdata, input logic we,
                                 input out_t exp);
        sb_item_t item;
        @(negedge clk);
        rst             = r;
        register_input  = seed;
        instruction     = instr;
        in_new_pc_value = pc;
        write_register  = wreg;
        write_data      = wdata;
        in_RegWrite     = we;
        item.name = name;
        item.exp  = exp;
        sb_q.push_back(item);
    endtask

    task automatic checkOutput(input sb_item_t item);
        tests++;
        if (actual !== item.exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", item.name, actual, item.exp);
        end
    endtask

    // Every clock presents a new ID/EX value; one expectation is consumed per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    initial begin
        applyStimulus("reset", 1'b1, 32'hA5A5_0001, 32'h00A0_0820, 32'h0000_0100, 6'd5, 32'h1111_1111, 1'b1,
                      ZERO);
        applyStimulus("read_r0_r7", 1'b0, 32'hA5A5_0001, 32'h0007_1820, 32'h0000_0104, 6'd0, 32'h0, 1'b0,
                      mk(5'd3, 5'd7, 32'h0000_1820, 32'h0, 32'hA5A5_0001, 32'h0000_0104, CTL_R, 3'b010, 2'b00));
        applyStimulus("bypass_add", 1'b0, 32'hA5A5_0001, 32'h00A0_0820, 32'h0000_0108, 6'd5, 32'h1234_5678, 1'b1,
                      mk(5'd1, 5'd0, 32'h0000_0820, 32'h1234_5678, 32'h0, 32'h0000_0108, CTL_R, 3'b010, 2'b00));
        applyStimulus("write_r0", 1'b0, 32'hA5A5_0001, 32'h0005_1020, 32'h0000_010C, 6'd0, 32'hFFFF_FFFF, 1'b1,
                      mk(5'd2, 5'd5, 32'h0000_1020, 32'h0, 32'h1234_5678, 32'h0000_010C, CTL_R, 3'b010, 2'b00));
        applyStimulus("read_r0_after", 1'b0, 32'hA5A5_0001, 32'h0000_1820, 32'h0000_0110, 6'h26, 32'hCAFE_F00D, 1'b1,
                      mk(5'd3, 5'd0, 32'h0000_1820, 32'h0, 32'h0, 32'h0000_0110, CTL_R, 3'b010, 2'b00));
        applyStimulus("lb", 1'b0, 32'hA5A5_0001, 32'h8062_FFFC, 32'h0000_0114, 6'd0, 32'h0, 1'b0,
                      mk(5'd31, 5'd2, 32'hFFFF_FFFC, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0000_0114, CTL_LD, 3'b000, 2'b01));
        applyStimulus("sw_wreg_bit5", 1'b0, 32'hA5A5_0001, 32'hACC6_0008, 32'h0000_0118, 6'd0, 32'h0, 1'b0,
                      mk(5'd0, 5'd6, 32'h0000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0000_0118, CTL_SW, 3'b000, 2'b00));
        applyStimulus("beq", 1'b0, 32'hA5A5_0001, 32'h1043_0010, 32'h0000_011C, 6'd0, 32'h0, 1'b0,
                      mk(5'd0, 5'd3, 32'h0000_0010, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0000_011C, CTL_BEQ, 3'b001, 2'b00));
        applyStimulus("op3f_nop", 1'b0, 32'hA5A5_0001, 32'hFC26_8001, 32'h0000_0120, 6'd0, 32'h0, 1'b0,
                      mk(5'd16, 5'd6, 32'hFFFF_8001, 32'hA5A5_0001, 32'hCAFE_F00D, 32'h0000_0120, 7'b0, 3'b000, 2'b00));
        applyStimulus("lbu", 1'b0, 32'hA5A5_0001, 32'h90C4_7FFF, 32'h0000_0124, 6'd0, 32'h0, 1'b0,
                      mk(5'd15, 5'd4, 32'h0000_7FFF, 32'hCAFE_F00D, 32'hA5A5_0001, 32'h0000_0124, CTL_LD, 3'b000, 2'b10));
        applyStimulus("lw", 1'b0, 32'hA5A5_0001, 32'h8CA9_0004, 32'h0000_0128, 6'd0, 32'h0, 1'b0,
                      mk(5'd0, 5'd9, 32'h0000_0004, 32'h1234_5678, 32'hA5A5_0001, 32'h0000_0128, CTL_LD, 3'b000, 2'b00));
        applyStimulus("addi_bypass2", 1'b0, 32'hA5A5_0001, 32'h2021_FFFF, 32'h0000_012C, 6'd1, 32'h0000_0042, 1'b1,
                      mk(5'd31, 5'd1, 32'hFFFF_FFFF, 32'h0000_0042, 32'h0000_0042, 32'h0000_012C, CTL_IMM, 3'b000, 2'b00));
        applyStimulus("slti", 1'b0, 32'hA5A5_0001, 32'h2828_0005, 32'h0000_0130, 6'd0, 32'h0, 1'b0,
                      mk(5'd0, 5'd8, 32'h0000_0005, 32'h0000_0042, 32'hA5A5_0001, 32'h0000_0130, CTL_IMM, 3'b101, 2'b00));
        applyStimulus("mid_reset", 1'b1, 32'h0BAD_0002, 32'h00A1_1820, 32'h0000_0134, 6'd5, 32'hDEAD_BEEF, 1'b1,
                      ZERO);
        applyStimulus("reseeded", 1'b0, 32'h0BAD_0002, 32'h00A1_1820, 32'h0000_0138, 6'd0, 32'h0, 1'b0,
                      mk(5'd3, 5'd1, 32'h0000_1820, 32'h0BAD_0002, 32'h0BAD_0002, 32'h0000_0138, CTL_R, 3'b010, 2'b00));
        applyStimulus("r0_after_reset", 1'b0, 32'h0BAD_0002, 32'h0006_1020, 32'h0000_013C, 6'd0, 32'h0, 1'b0,
                      mk(5'd2, 5'd6, 32'h0000_1020, 32'h0, 32'h0BAD_0002, 32'h0000_013C, CTL_R, 3'b010, 2'b00));

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
